// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunk-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Saturation limits, returned in 64 bits and truncated to WIDTH by the caller.
    function automatic logic [63:0] sat_pos_const(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_const(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seq_chunk.sv
// CHUNK-bit ripple-carry adder slice, reused once per cycle by addsub_seq.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] s;
    logic             c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

    assign sum  = s;
    assign cout = c;

endmodule

// File: rtl/addsub_seq.sv
// Sequential two's-complement adder/subtractor: one CHUNK-bit slice per clock,
// optional saturation, valid/ready handshake on both sides.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Cout,
    output logic             Zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_const(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_const(WIDTH));

    if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("addsub_seq: WIDTH must be >= 2 and an integer multiple of CHUNK >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             sat_q, sat_d, carry_q, carry_d;
    logic             ovfl_q, ovfl_d, cout_q, cout_d, zero_q, zero_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
    logic             ch_cout;
    logic [WIDTH-1:0] raw, final_sum;
    logic             raw_ovfl;

    always_comb begin
        ch_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
        ch_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (carry_q),
        .sum  (ch_sum),
        .cout (ch_cout)
    );

    // Result register with the current slice merged in; complete on the last chunk.
    always_comb begin
        raw = res_q;
        raw[int'(idx_q) * CHUNK +: CHUNK] = ch_sum;
    end

    assign raw_ovfl  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
    assign final_sum = (sat_q && raw_ovfl) ? (a_q[WIDTH-1] ? SAT_NEG : SAT_POS) : raw;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    sat_d   = sat;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = raw;
                carry_d = ch_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    sum_d   = final_sum;
                    ovfl_d  = raw_ovfl;
                    cout_d  = ch_cout;
                    zero_d  = (final_sum == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    sum_d   = '0;
                    ovfl_d  = 1'b0;
                    cout_d  = 1'b0;
                    zero_d  = 1'b0;
                    carry_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            ovfl_q      <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            ovfl_q      <= ovfl_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
        end
    end

    // Operand and partial-result storage is only meaningful inside an operation.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sat_q <= sat_d;
        res_q <= res_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Ovfl      = ovfl_q;
    assign Cout      = cout_q;
    assign Zero      = zero_q;

endmodule
